// File: rtl/register_file.sv
// Register-read stage: 31x32 integer register file with writeback bypass,
// per-register pending-write scoreboard and a 1-entry registered output slice.
module register_file #(
  parameter int XLEN     = 32,
  parameter int SB_CNT_W = 2,
  parameter int ID_W     = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_idrf_tvalid,
  output logic                     o_idrf_tready,
  input  logic [ID_W-1:0]          i_idrf_tdata,
  output logic                     o_rfex_tvalid,
  input  logic                     i_rfex_tready,
  output logic [ID_W+2*XLEN-1:0]   o_rfex_tdata,
  input  logic                     i_wb_vld,
  input  logic [4:0]               i_wb_rd,
  input  logic [XLEN-1:0]          i_wb_data,
  input  logic                     i_invalidate
);

  localparam int                  OUT_W   = ID_W + 2 * XLEN;
  localparam logic [SB_CNT_W-1:0] CNT_MAX = {SB_CNT_W{1'b1}};

  // Decoded instruction layout: {opaque[ID_W-1:15], rd[14:10], rs2[9:5], rs1[4:0]}
  logic [4:0]          w_rs1;
  logic [4:0]          w_rs2;
  logic [4:0]          w_rd;
  logic                w_rs1_hit;
  logic                w_rs2_hit;
  logic                w_rd_hit;
  logic [XLEN-1:0]     w_rs1_data;
  logic [XLEN-1:0]     w_rs2_data;
  logic                w_rd_full;
  logic                w_hazard;
  logic                w_hs_in;

  logic [XLEN-1:0]     r_regs [32];
  logic [SB_CNT_W-1:0] r_cnt [32];
  logic [SB_CNT_W-1:0] w_cnt_nxt [32];
  logic                r_rfex_tvalid;
  logic [OUT_W-1:0]    r_rfex_tdata;

  // A source is busy while writes remain outstanding after this cycle's writeback.
  function automatic logic src_busy(input logic [4:0] rs, input logic [SB_CNT_W-1:0] cnt,
                                    input logic hit);
    return (rs != 5'd0) && (cnt > SB_CNT_W'(hit));
  endfunction

  assign w_rs1     = i_idrf_tdata[4:0];
  assign w_rs2     = i_idrf_tdata[9:5];
  assign w_rd      = i_idrf_tdata[14:10];
  assign w_rs1_hit = i_wb_vld && (i_wb_rd == w_rs1);
  assign w_rs2_hit = i_wb_vld && (i_wb_rd == w_rs2);
  assign w_rd_hit  = i_wb_vld && (i_wb_rd == w_rd);

  // Operand read with same-cycle writeback bypass; x0 always reads zero.
  always_comb begin
    w_rs1_data = {XLEN{1'b0}};
    w_rs2_data = {XLEN{1'b0}};
    if (w_rs1 == 5'd0) w_rs1_data = {XLEN{1'b0}};
    else if (w_rs1_hit) w_rs1_data = i_wb_data;
    else w_rs1_data = r_regs[w_rs1];
    if (w_rs2 == 5'd0) w_rs2_data = {XLEN{1'b0}};
    else if (w_rs2_hit) w_rs2_data = i_wb_data;
    else w_rs2_data = r_regs[w_rs2];
  end

  assign w_rd_full = (w_rd != 5'd0) && (r_cnt[w_rd] == CNT_MAX) && !w_rd_hit;
  assign w_hazard  = src_busy(w_rs1, r_cnt[w_rs1], w_rs1_hit)
                   | src_busy(w_rs2, r_cnt[w_rs2], w_rs2_hit) | w_rd_full;

  assign o_idrf_tready = i_rst && !i_invalidate && !w_hazard && (!r_rfex_tvalid || i_rfex_tready);
  assign w_hs_in       = i_idrf_tvalid && o_idrf_tready;

  // Scoreboard next state: issue increments, writeback decrements (saturating at 0).
  always_comb begin
    for (int r = 0; r < 32; r++) begin
      w_cnt_nxt[r] = r_cnt[r];
      case ({w_hs_in && (w_rd == 5'(r)), i_wb_vld && (i_wb_rd == 5'(r))})
        2'b10:   w_cnt_nxt[r] = r_cnt[r] + SB_CNT_W'(1'b1);
        2'b01:   w_cnt_nxt[r] = (r_cnt[r] == {SB_CNT_W{1'b0}}) ? {SB_CNT_W{1'b0}}
                                                                 : r_cnt[r] - SB_CNT_W'(1'b1);
        default: w_cnt_nxt[r] = r_cnt[r];
      endcase
    end
    w_cnt_nxt[0] = {SB_CNT_W{1'b0}};
  end

  // Scoreboard state; a flush discards all outstanding-write bookkeeping.
  always_ff @(posedge i_clk) begin
    for (int r = 0; r < 32; r++) begin
      if (!i_rst || i_invalidate) r_cnt[r] <= {SB_CNT_W{1'b0}};
      else r_cnt[r] <= w_cnt_nxt[r];
    end
  end

  // Register array: writeback is never blocked, x0 is not stored.
  always_ff @(posedge i_clk) begin
    if (i_wb_vld && (i_wb_rd != 5'd0)) r_regs[i_wb_rd] <= i_wb_data;
  end

  // Output slice: load on input handshake, clear on drain, reset or flush.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_rfex_tvalid <= 1'b0;
      r_rfex_tdata  <= {OUT_W{1'b0}};
    end else if (i_invalidate) begin
      r_rfex_tvalid <= 1'b0;
    end else if (w_hs_in) begin
      r_rfex_tvalid <= 1'b1;
      r_rfex_tdata  <= {i_idrf_tdata, w_rs1_data, w_rs2_data};
    end else if (i_rfex_tready) begin
      r_rfex_tvalid <= 1'b0;
    end else begin
      r_rfex_tvalid <= r_rfex_tvalid;
    end
  end

  assign o_rfex_tvalid = r_rfex_tvalid;
  assign o_rfex_tdata  = r_rfex_tdata;

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: one task per scenario, inline comparisons.
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        idrf_tvalid;
  logic        idrf_tready;
  logic [31:0] idrf_tdata;
  logic        rfex_tvalid;
  logic        rfex_tready;
  logic [95:0] rfex_tdata;
  logic        wb_vld;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        invalidate;

  int total = 0;
  int bad   = 0;

  register_file dut (
    .i_clk(clk), .i_rst(rst),
    .i_idrf_tvalid(idrf_tvalid), .o_idrf_tready(idrf_tready), .i_idrf_tdata(idrf_tdata),
    .o_rfex_tvalid(rfex_tvalid), .i_rfex_tready(rfex_tready), .o_rfex_tdata(rfex_tdata),
    .i_wb_vld(wb_vld), .i_wb_rd(wb_rd), .i_wb_data(wb_data), .i_invalidate(invalidate)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input logic [16:0] tag);
    return {tag, rd, rs2, rs1};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; idrf_tvalid = 1'b1; idrf_tdata = mk(5'd1, 5'd0, 5'd0, 17'h1);
    cyc(); cyc();
    total++; if (idrf_tready !== 1'b0) begin bad++; $display("FAIL rst_tready got=%b exp=0", idrf_tready); end
    total++; if (rfex_tvalid !== 1'b0) begin bad++; $display("FAIL rst_tvalid got=%b exp=0", rfex_tvalid); end
    idrf_tvalid = 1'b0; rst = 1'b1;
    cyc();
  endtask

  task automatic test_issue();
    logic [31:0] a, b;
    a = mk(5'd1, 5'd0, 5'd0, 17'h00a);
    b = mk(5'd0, 5'd1, 5'd0, 17'h00b);
    idrf_tdata = a; idrf_tvalid = 1'b1; #1;
    total++; if (idrf_tready !== 1'b1) begin bad++; $display("FAIL addi_tready got=%b exp=1", idrf_tready); end
    cyc(); idrf_tvalid = 1'b0;
    total++; if (rfex_tvalid !== 1'b1) begin bad++; $display("FAIL addi_tvalid got=%b exp=1", rfex_tvalid); end
    total++; if (rfex_tdata !== {a, 32'h0, 32'h0}) begin bad++; $display("FAIL addi_data got=%h exp=%h", rfex_tdata, {a, 32'h0, 32'h0}); end
    idrf_tdata = b; idrf_tvalid = 1'b1; #1;
    total++; if (idrf_tready !== 1'b0) begin bad++; $display("FAIL cnt1_stall got=%b exp=0", idrf_tready); end
    wb_vld = 1'b1; wb_rd = 5'd1; wb_data = 32'h0000_0011; #1;
    total++; if (idrf_tready !== 1'b1) begin bad++; $display("FAIL cnt1_wb_release got=%b exp=1", idrf_tready); end
    cyc(); wb_vld = 1'b0; idrf_tvalid = 1'b0;
    total++; if (rfex_tdata !== {b, 32'h11, 32'h0}) begin bad++; $display("FAIL x1_bypass got=%h exp=%h", rfex_tdata, {b, 32'h11, 32'h0}); end
    cyc();
    total++; if (rfex_tvalid !== 1'b0) begin bad++; $display("FAIL issue_drain got=%b exp=0", rfex_tvalid); end
  endtask

  task automatic test_raw();
    logic [31:0] a, b, c;
    a = mk(5'd5, 5'd0, 5'd0, 17'h050);
    b = mk(5'd9, 5'd5, 5'd0, 17'h051);
    c = mk(5'd0, 5'd5, 5'd0, 17'h052);
    idrf_tdata = a; idrf_tvalid = 1'b1;
    cyc();
    idrf_tdata = b; #1;
    total++; if (idrf_tready !== 1'b0) begin bad++; $display("FAIL raw_stall got=%b exp=0", idrf_tready); end
    cyc();
    total++; if (idrf_tready !== 1'b0) begin bad++; $display("FAIL raw_stall2 got=%b exp=0", idrf_tready); end
    total++; if (rfex_tvalid !== 1'b0) begin bad++; $display("FAIL raw_bubble got=%b exp=0", rfex_tvalid); end
    wb_vld = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF; #1;
    total++; if (idrf_tready !== 1'b1) begin bad++; $display("FAIL raw_release got=%b exp=1", idrf_tready); end
    cyc(); wb_vld = 1'b0;
    total++; if (rfex_tdata !== {b, 32'hDEAD_BEEF, 32'h0}) begin bad++; $display("FAIL raw_bypass got=%h exp=%h", rfex_tdata, {b, 32'hDEAD_BEEF, 32'h0}); end
    idrf_tdata = c; #1;
    total++; if (idrf_tready !== 1'b1) begin bad++; $display("FAIL cnt5_zero got=%b exp=1", idrf_tready); end
    cyc(); idrf_tvalid = 1'b0;
    total++; if (rfex_tdata !== {c, 32'hDEAD_BEEF, 32'h0}) begin bad++; $display("FAIL x5_array got=%h exp=%h", rfex_tdata, {c, 32'hDEAD_BEEF, 32'h0}); end
    cyc();
  endtask

  task automatic test_back_to_back();
    logic [31:0] t;
    idrf_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      t = mk(5'd7, 5'd0, 5'd0, 17'(32'h070 + i));
      idrf_tdata = t; #1;
      total++; if (idrf_tready !== 1'b1) begin bad++; $display("FAIL b2b_tready%0d got=%b exp=1", i, idrf_tready); end
      cyc();
      total++; if (rfex_tdata !== {t, 32'h0, 32'h0}) begin bad++; $display("FAIL b2b_data%0d got=%h exp=%h", i, rfex_tdata, {t, 32'h0, 32'h0}); end
    end
    t = mk(5'd7, 5'd0, 5'd0, 17'h07f);
    idrf_tdata = t; #1;
    total++; if (idrf_tready !== 1'b0) begin bad++; $display("FAIL rd_full got=%b exp=0", idrf_tready); end
    cyc();
    total++; if (idrf_tready !== 1'b0) begin bad++; $display("FAIL rd_full2 got=%b exp=0", idrf_tready); end
    total++; if (rfex_tvalid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", rfex_tvalid); end
    wb_vld = 1'b1; wb_rd = 5'd7; wb_data = 32'h0000_0077; #1;
    total++; if (idrf_tready !== 1'b1) begin bad++; $display("FAIL rd_full_wb got=%b exp=1", idrf_tready); end
    cyc(); wb_vld = 1'b0; idrf_tvalid = 1'b0;
    total++; if (rfex_tdata !== {t, 32'h0, 32'h0}) begin bad++; $display("FAIL rd_full_data got=%h exp=%h", rfex_tdata, {t, 32'h0, 32'h0}); end
    idrf_tdata = mk(5'd0, 5'd7, 5'd0, 17'h07e); idrf_tvalid = 1'b1; #1;
    total++; if (idrf_tready !== 1'b0) begin bad++; $display("FAIL cnt7_still3 got=%b exp=0", idrf_tready); end
    idrf_tvalid = 1'b0;
    cyc();
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b;
    a = mk(5'd0, 5'd5, 5'd0, 17'h0a0);
    b = mk(5'd0, 5'd0, 5'd0, 17'h0b0);
    rfex_tready = 1'b0; idrf_tdata = a; idrf_tvalid = 1'b1;
    cyc();
    idrf_tdata = b;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (idrf_tready !== 1'b0) begin bad++; $display("FAIL bp_tready%0d got=%b exp=0", i, idrf_tready); end
      total++; if (rfex_tvalid !== 1'b1) begin bad++; $display("FAIL bp_tvalid%0d got=%b exp=1", i, rfex_tvalid); end
      total++; if (rfex_tdata !== {a, 32'hDEAD_BEEF, 32'h0}) begin bad++; $display("FAIL bp_hold%0d got=%h exp=%h", i, rfex_tdata, {a, 32'hDEAD_BEEF, 32'h0}); end
      cyc();
    end
    rfex_tready = 1'b1; #1;
    total++; if (idrf_tready !== 1'b1) begin bad++; $display("FAIL bp_release got=%b exp=1", idrf_tready); end
    cyc(); idrf_tvalid = 1'b0;
    total++; if (rfex_tdata !== {b, 32'h0, 32'h0}) begin bad++; $display("FAIL bp_next got=%h exp=%h", rfex_tdata, {b, 32'h0, 32'h0}); end
    cyc();
    total++; if (rfex_tvalid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b exp=0", rfex_tvalid); end
  endtask

  task automatic test_invalidate();
    logic [31:0] c, d;
    c = mk(5'd0, 5'd3, 5'd10, 17'h0c0);
    d = mk(5'd0, 5'd3, 5'd0, 17'h0d0);
    wb_vld = 1'b1; wb_rd = 5'd3; wb_data = 32'h0000_0033;
    cyc(); wb_vld = 1'b0;
    idrf_tvalid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      idrf_tdata = mk(5'd3, 5'd0, 5'd0, 17'(32'h030 + i)); #1;
      total++; if (idrf_tready !== 1'b1) begin bad++; $display("FAIL inv_issue%0d got=%b exp=1", i, idrf_tready); end
      cyc();
    end
    rfex_tready = 1'b0; idrf_tdata = d; #1;
    total++; if (idrf_tready !== 1'b0) begin bad++; $display("FAIL inv_pre_stall got=%b exp=0", idrf_tready); end
    invalidate = 1'b1; wb_vld = 1'b1; wb_rd = 5'd10; wb_data = 32'hA5A5_A5A5; #1;
    total++; if (idrf_tready !== 1'b0) begin bad++; $display("FAIL inv_tready got=%b exp=0", idrf_tready); end
    cyc(); invalidate = 1'b0; wb_vld = 1'b0;
    total++; if (rfex_tvalid !== 1'b0) begin bad++; $display("FAIL inv_tvalid got=%b exp=0", rfex_tvalid); end
    rfex_tready = 1'b1; idrf_tdata = c; #1;
    total++; if (idrf_tready !== 1'b1) begin bad++; $display("FAIL inv_cnt_clear got=%b exp=1", idrf_tready); end
    cyc(); idrf_tvalid = 1'b0;
    total++; if (rfex_tdata !== {c, 32'h33, 32'hA5A5_A5A5}) begin bad++; $display("FAIL inv_data got=%h exp=%h", rfex_tdata, {c, 32'h33, 32'hA5A5_A5A5}); end
    wb_vld = 1'b1; wb_rd = 5'd3; wb_data = 32'h0000_0333;
    cyc(); wb_vld = 1'b0;
    idrf_tdata = d; idrf_tvalid = 1'b1; #1;
    total++; if (idrf_tready !== 1'b1) begin bad++; $display("FAIL stale_wb_sat got=%b exp=1", idrf_tready); end
    cyc(); idrf_tvalid = 1'b0;
    total++; if (rfex_tdata !== {d, 32'h333, 32'h0}) begin bad++; $display("FAIL stale_wb_data got=%h exp=%h", rfex_tdata, {d, 32'h333, 32'h0}); end
    cyc();
  endtask

  task automatic test_x0();
    logic [31:0] t;
    wb_vld = 1'b1; wb_rd = 5'd0; wb_data = 32'h0000_1234; idrf_tvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      t = mk(5'd0, 5'd0, 5'd0, 17'(32'h0e0 + i));
      idrf_tdata = t; #1;
      total++; if (idrf_tready !== 1'b1) begin bad++; $display("FAIL x0_tready%0d got=%b exp=1", i, idrf_tready); end
      cyc();
      wb_vld = 1'b0;
      total++; if (rfex_tdata !== {t, 32'h0, 32'h0}) begin bad++; $display("FAIL x0_data%0d got=%h exp=%h", i, rfex_tdata, {t, 32'h0, 32'h0}); end
    end
    idrf_tvalid = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid_stall();
    idrf_tdata = mk(5'd12, 5'd0, 5'd0, 17'h120); idrf_tvalid = 1'b1;
    cyc();
    rfex_tready = 1'b0; idrf_tdata = mk(5'd0, 5'd12, 5'd0, 17'h121); #1;
    total++; if (idrf_tready !== 1'b0) begin bad++; $display("FAIL mid_stall got=%b exp=0", idrf_tready); end
    rst = 1'b0;
    cyc();
    total++; if (rfex_tvalid !== 1'b0) begin bad++; $display("FAIL mid_rst_tvalid got=%b exp=0", rfex_tvalid); end
    rst = 1'b1; rfex_tready = 1'b1; #1;
    total++; if (idrf_tready !== 1'b1) begin bad++; $display("FAIL mid_rst_cnt got=%b exp=1", idrf_tready); end
    cyc(); idrf_tvalid = 1'b0;
    total++; if (rfex_tvalid !== 1'b1) begin bad++; $display("FAIL mid_rst_issue got=%b exp=1", rfex_tvalid); end
    cyc();
  endtask

  initial begin
    rst = 1'b0; idrf_tvalid = 1'b0; idrf_tdata = 32'h0; rfex_tready = 1'b1;
    wb_vld = 1'b0; wb_rd = 5'd0; wb_data = 32'h0; invalidate = 1'b0;
    #1;
    test_reset();
    test_issue();
    test_raw();
    test_back_to_back();
    test_backpressure();
    test_invalidate();
    test_x0();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
